// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle datapath controller.
// No logic: states, opcodes, mux-select encodings and the control bundle.
// Imported by the controller top and its output decoder.
package mc_pkg;

    // Controller states; FETCH must be the all-zero encoding (reset value).
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADR   = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EX   = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_ILLEGAL   = 4'd12
    } state_e;

    // Instruction opcodes (instruction_register[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation class.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full set of datapath control lines driven by the decoder.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_t;

endpackage

// File: rtl/mc_control_decode.sv
// Maps controller state (plus mem_ready/zero) to datapath control lines.
// Latency: purely combinational, same cycle as state and inputs.
// Backpressure: FETCH IR/PC writes follow mem_ready; en_i=0 forces all outputs low.
module mc_control_decode
    import mc_pkg::*;
(
    input  logic   en_i,
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   zero_i,
    output ctl_t   ctl_o,
    output logic   pc_en_o,
    output logic   illegal_op_o
);

    // Per-state control values; anything not set for a state stays 0.
    always_comb begin
        ctl_o        = '0;
        illegal_op_o = 1'b0;
        if (en_i) begin
            case (state_i)
                ST_FETCH: begin
                    ctl_o.mem_read  = 1'b1;
                    ctl_o.alu_src_b = SRCB_FOUR;
                    ctl_o.alu_op    = ALUOP_ADD;
                    ctl_o.pc_source = PCSRC_ALU;
                    // IR and PC only capture once the instruction word arrives.
                    ctl_o.ir_write  = mem_ready_i;
                    ctl_o.pc_write  = mem_ready_i;
                end
                ST_DECODE: begin
                    ctl_o.alu_src_b = SRCB_IMM_SH;
                    ctl_o.alu_op    = ALUOP_ADD;
                end
                ST_MEM_ADR, ST_ADDI_EX: begin
                    ctl_o.alu_src_a = 1'b1;
                    ctl_o.alu_src_b = SRCB_IMM;
                    ctl_o.alu_op    = ALUOP_ADD;
                end
                ST_MEM_READ: begin
                    ctl_o.mem_read = 1'b1;
                    ctl_o.iord     = 1'b1;
                end
                ST_MEM_WRITE: begin
                    ctl_o.mem_write = 1'b1;
                    ctl_o.iord      = 1'b1;
                end
                ST_MEM_WB: begin
                    ctl_o.mem_to_reg = 1'b1;
                    ctl_o.reg_write  = 1'b1;
                end
                ST_EXECUTE: begin
                    ctl_o.alu_src_a = 1'b1;
                    ctl_o.alu_src_b = SRCB_REG;
                    ctl_o.alu_op    = ALUOP_FUNCT;
                end
                ST_R_WB: begin
                    ctl_o.reg_dst   = 1'b1;
                    ctl_o.reg_write = 1'b1;
                end
                ST_ADDI_WB: begin
                    ctl_o.reg_write = 1'b1;
                end
                ST_BRANCH: begin
                    ctl_o.alu_src_a     = 1'b1;
                    ctl_o.alu_src_b     = SRCB_REG;
                    ctl_o.alu_op        = ALUOP_SUB;
                    ctl_o.pc_write_cond = 1'b1;
                    ctl_o.pc_source     = PCSRC_ALUOUT;
                end
                ST_JUMP: begin
                    ctl_o.pc_write  = 1'b1;
                    ctl_o.pc_source = PCSRC_JUMP;
                end
                ST_ILLEGAL: begin
                    illegal_op_o = 1'b1;
                end
                default: begin
                    ctl_o = '0;
                end
            endcase
        end
    end

    // PC load enable: unconditional write, or branch taken on ALU zero.
    assign pc_en_o = ctl_o.pc_write | (ctl_o.pc_write_cond & zero_i);

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU controller: state register and next-state logic.
// Latency: FETCH-to-FETCH lw 5, sw/R/addi 4, beq/j 3 cycles with mem_ready high.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready=1.
module mc_control
    import mc_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_e state_q, state_d;
    ctl_t   ctl;

    // State register; reset drops straight back to FETCH, aborting any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from current state, opcode and memory handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            // Only lw/sw reach here; anything other than sw is treated as a load.
            ST_MEM_ADR:   state_d = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ: begin
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WRITE: begin
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXECUTE:   state_d = ST_R_WB;
            ST_ADDI_EX:   state_d = ST_ADDI_WB;
            ST_MEM_WB,
            ST_R_WB,
            ST_ADDI_WB,
            ST_BRANCH,
            ST_JUMP:      state_d = ST_FETCH;
            ST_ILLEGAL: begin
                if (!HALT_ON_ILLEGAL) state_d = ST_FETCH;
            end
            default:      state_d = ST_FETCH;
        endcase
    end

    // Outputs are held low while reset is asserted via the decoder enable.
    mc_control_decode u_decode (
        .en_i         (reset),
        .state_i      (state_q),
        .mem_ready_i  (mem_ready),
        .zero_i       (zero),
        .ctl_o        (ctl),
        .pc_en_o      (pc_en),
        .illegal_op_o (illegal_op)
    );

    assign IorD        = ctl.iord;
    assign MemRead     = ctl.mem_read;
    assign MemWrite    = ctl.mem_write;
    assign IRWrite     = ctl.ir_write;
    assign RegDst      = ctl.reg_dst;
    assign MemtoReg    = ctl.mem_to_reg;
    assign RegWrite    = ctl.reg_write;
    assign ALUSrcA     = ctl.alu_src_a;
    assign PCWrite     = ctl.pc_write;
    assign PCWriteCond = ctl.pc_write_cond;
    assign ALUSrcB     = ctl.alu_src_b;
    assign ALUOp       = ctl.alu_op;
    assign PCSource    = ctl.pc_source;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: table vectors, directed corners, random run.
// Two instances (halting and non-halting on illegal opcodes) share the stimulus.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_mc_control;
    import mc_pkg::*;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_ADDI = 6'b001000;

    typedef struct packed {
        logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic       pcwrite, pcwritecond;
        logic [1:0] alusrcb, aluop, pcsource;
        logic       pc_en, illegal;
    } tctl_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         n;
        state_e     st[5];
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0] opcode = '0;
    logic mem_ready = 1'b0;
    logic zero = 1'b0;

    logic h_IorD, h_MemRead, h_MemWrite, h_IRWrite, h_RegDst, h_MemtoReg, h_RegWrite;
    logic h_ALUSrcA, h_PCWrite, h_PCWriteCond, h_pc_en, h_illegal_op;
    logic [1:0] h_ALUSrcB, h_ALUOp, h_PCSource;
    logic [3:0] h_state_dbg;
    logic r_IorD, r_MemRead, r_MemWrite, r_IRWrite, r_RegDst, r_MemtoReg, r_RegWrite;
    logic r_ALUSrcA, r_PCWrite, r_PCWriteCond, r_pc_en, r_illegal_op;
    logic [1:0] r_ALUSrcB, r_ALUOp, r_PCSource;
    logic [3:0] r_state_dbg;

    tctl_t ch, cr;
    assign ch = {h_IorD, h_MemRead, h_MemWrite, h_IRWrite, h_RegDst, h_MemtoReg, h_RegWrite,
                 h_ALUSrcA, h_PCWrite, h_PCWriteCond, h_ALUSrcB, h_ALUOp, h_PCSource,
                 h_pc_en, h_illegal_op};
    assign cr = {r_IorD, r_MemRead, r_MemWrite, r_IRWrite, r_RegDst, r_MemtoReg, r_RegWrite,
                 r_ALUSrcA, r_PCWrite, r_PCWriteCond, r_ALUSrcB, r_ALUOp, r_PCSource,
                 r_pc_en, r_illegal_op};

    always #5 clk = ~clk;

    mc_control #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .IorD(h_IorD), .MemRead(h_MemRead), .MemWrite(h_MemWrite), .IRWrite(h_IRWrite),
        .RegDst(h_RegDst), .MemtoReg(h_MemtoReg), .RegWrite(h_RegWrite), .ALUSrcA(h_ALUSrcA),
        .PCWrite(h_PCWrite), .PCWriteCond(h_PCWriteCond), .ALUSrcB(h_ALUSrcB), .ALUOp(h_ALUOp),
        .PCSource(h_PCSource), .pc_en(h_pc_en), .illegal_op(h_illegal_op), .state_dbg(h_state_dbg)
    );

    mc_control #(.HALT_ON_ILLEGAL(1'b0)) dut_r (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .IorD(r_IorD), .MemRead(r_MemRead), .MemWrite(r_MemWrite), .IRWrite(r_IRWrite),
        .RegDst(r_RegDst), .MemtoReg(r_MemtoReg), .RegWrite(r_RegWrite), .ALUSrcA(r_ALUSrcA),
        .PCWrite(r_PCWrite), .PCWriteCond(r_PCWriteCond), .ALUSrcB(r_ALUSrcB), .ALUOp(r_ALUOp),
        .PCSource(r_PCSource), .pc_en(r_pc_en), .illegal_op(r_illegal_op), .state_dbg(r_state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int mw_cnt = 0;
    int rw_cnt = 0;

    // Expected control lines for a state, written from the per-state output lists.
    function automatic tctl_t exp_ctl(input state_e s, input logic mr, input logic z);
        tctl_t c;
        c = '0;
        case (s)
            ST_FETCH:     begin c.memread = 1'b1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
            ST_DECODE:    c.alusrcb = 2'b11;
            ST_MEM_ADR,
            ST_ADDI_EX:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ST_MEM_READ:  begin c.memread = 1'b1; c.iord = 1'b1; end
            ST_MEM_WRITE: begin c.memwrite = 1'b1; c.iord = 1'b1; end
            ST_MEM_WB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            ST_EXECUTE:   begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            ST_R_WB:      begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            ST_ADDI_WB:   c.regwrite = 1'b1;
            ST_BRANCH:    begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'b01; end
            ST_JUMP:      begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
            ST_ILLEGAL:   c.illegal = 1'b1;
            default:      c = '0;
        endcase
        c.pc_en = c.pcwrite | (c.pcwritecond & z);
        return c;
    endfunction

    function automatic bit is_mem(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs, sample mid-cycle, compare both instances, advance.
    task automatic drive_check(input logic [5:0] op, input logic mr, input logic z,
                               input state_e es, input string nm);
        tctl_t e;
        opcode = op; mem_ready = mr; zero = z;
        @(negedge clk);
        e = exp_ctl(es, mr, z);
        chk({nm, " state"}, 32'(h_state_dbg), 32'(es));
        chk({nm, " ctl"}, 32'(ch), 32'(e));
        chk({nm, " state(nohalt)"}, 32'(r_state_dbg), 32'(es));
        chk({nm, " ctl(nohalt)"}, 32'(cr), 32'(e));
        if (ch.memwrite) mw_cnt++;
        if (ch.regwrite) rw_cnt++;
        @(posedge clk); #1;
    endtask

    // Reference sequence of phases for one instruction, with random memory stalls.
    task automatic run_instr(input logic [5:0] op, input int mr_pct, input string nm);
        state_e ph[$];
        ph = {ST_FETCH, ST_DECODE};
        case (op)
            OPC_LW:   ph = {ph, ST_MEM_ADR, ST_MEM_READ, ST_MEM_WB};
            OPC_SW:   ph = {ph, ST_MEM_ADR, ST_MEM_WRITE};
            OPC_R:    ph = {ph, ST_EXECUTE, ST_R_WB};
            OPC_ADDI: ph = {ph, ST_ADDI_EX, ST_ADDI_WB};
            OPC_BEQ:  ph = {ph, ST_BRANCH};
            default:  ph = {ph, ST_JUMP};
        endcase
        foreach (ph[i]) begin
            int   w;
            logic mr;
            logic [5:0] o;
            w = 0;
            do begin
                if (is_mem(ph[i])) mr = (int'($urandom_range(99)) < mr_pct) || (w >= 4);
                else               mr = 1'($urandom_range(1));
                o = (ph[i] == ST_FETCH) ? 6'($urandom) : op;
                drive_check(o, mr, 1'($urandom_range(1)), ph[i], nm);
                w++;
            end while (is_mem(ph[i]) && !mr);
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    vec_t tbl[7];
    logic [5:0] legal_ops[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{OPC_LW,   1'b0, 5, '{ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_READ, ST_MEM_WB}};
        tbl[1] = '{OPC_SW,   1'b1, 4, '{ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_WRITE, ST_FETCH}};
        tbl[2] = '{OPC_R,    1'b0, 4, '{ST_FETCH, ST_DECODE, ST_EXECUTE, ST_R_WB, ST_FETCH}};
        tbl[3] = '{OPC_ADDI, 1'b1, 4, '{ST_FETCH, ST_DECODE, ST_ADDI_EX, ST_ADDI_WB, ST_FETCH}};
        tbl[4] = '{OPC_BEQ,  1'b1, 3, '{ST_FETCH, ST_DECODE, ST_BRANCH, ST_FETCH, ST_FETCH}};
        tbl[5] = '{OPC_BEQ,  1'b0, 3, '{ST_FETCH, ST_DECODE, ST_BRANCH, ST_FETCH, ST_FETCH}};
        tbl[6] = '{OPC_J,    1'b0, 3, '{ST_FETCH, ST_DECODE, ST_JUMP, ST_FETCH, ST_FETCH}};
        legal_ops = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_J, OPC_ADDI};

        // Reset asserted: everything low, FETCH shown, even with mem_ready high.
        mem_ready = 1'b1;
        #3;
        chk("reset ctl", 32'(ch), 32'h0);
        chk("reset state", 32'(h_state_dbg), 32'(ST_FETCH));
        chk("reset ctl(nohalt)", 32'(cr), 32'h0);
        release_reset();

        // Table vectors, mem_ready tied high.
        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].n; c++)
                drive_check(tbl[i].op, 1'b1, tbl[i].z, tbl[i].st[c], $sformatf("vec%0d c%0d", i, c));
        end

        // sw with three stalled MEM_WRITE cycles.
        mw_cnt = 0; rw_cnt = 0;
        drive_check(OPC_SW, 1'b1, 1'b0, ST_FETCH, "sw fetch");
        drive_check(OPC_SW, 1'b1, 1'b0, ST_DECODE, "sw decode");
        drive_check(OPC_SW, 1'b1, 1'b0, ST_MEM_ADR, "sw adr");
        for (int k = 0; k < 3; k++) drive_check(OPC_SW, 1'b0, 1'b0, ST_MEM_WRITE, "sw stall");
        drive_check(OPC_SW, 1'b1, 1'b0, ST_MEM_WRITE, "sw done");
        chk("sw memwrite cycles", 32'(mw_cnt), 32'd4);
        chk("sw regwrite cycles", 32'(rw_cnt), 32'd0);

        // FETCH stalled two cycles, then DECODE (FETCH re-entry after sw checked here too).
        drive_check(6'h3F, 1'b0, 1'b1, ST_FETCH, "fetch stall0");
        drive_check(6'h15, 1'b0, 1'b1, ST_FETCH, "fetch stall1");
        drive_check(6'h2A, 1'b1, 1'b1, ST_FETCH, "fetch go");
        drive_check(OPC_J, 1'b1, 1'b0, ST_DECODE, "j decode");
        drive_check(OPC_J, 1'b1, 1'b0, ST_JUMP, "j jump");

        // Illegal opcode: halting instance sticks, non-halting one refetches.
        drive_check(6'h00, 1'b1, 1'b0, ST_FETCH, "ill fetch");
        drive_check(6'h3F, 1'b1, 1'b0, ST_DECODE, "ill decode");
        drive_check(6'h3F, 1'b1, 1'b0, ST_ILLEGAL, "ill first");
        for (int k = 0; k < 11; k++) begin
            logic mr, z;
            mr = 1'($urandom_range(1)); z = 1'($urandom_range(1));
            opcode = 6'($urandom); mem_ready = mr; zero = z;
            @(negedge clk);
            chk("ill hold state", 32'(h_state_dbg), 32'(ST_ILLEGAL));
            chk("ill hold ctl", 32'(ch), 32'(exp_ctl(ST_ILLEGAL, mr, z)));
            if (k == 0) begin
                chk("nohalt refetch state", 32'(r_state_dbg), 32'(ST_FETCH));
                chk("nohalt refetch ctl", 32'(cr), 32'(exp_ctl(ST_FETCH, mr, z)));
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        release_reset();

        // Reset mid-MEM_READ with the access still pending.
        drive_check(OPC_LW, 1'b1, 1'b0, ST_FETCH, "rst lw fetch");
        drive_check(OPC_LW, 1'b1, 1'b0, ST_DECODE, "rst lw decode");
        drive_check(OPC_LW, 1'b1, 1'b0, ST_MEM_ADR, "rst lw adr");
        drive_check(OPC_LW, 1'b0, 1'b0, ST_MEM_READ, "rst lw read");
        #2;
        reset = 1'b0;
        #1;
        chk("midreset ctl", 32'(ch), 32'h0);
        chk("midreset state", 32'(h_state_dbg), 32'(ST_FETCH));
        chk("midreset ctl(nohalt)", 32'(cr), 32'h0);
        release_reset();
        run_instr(OPC_J, 100, "post-reset j");

        // Random instruction stream with random stalls, zero and FETCH-time opcode noise.
        for (int n = 0; n < 80; n++)
            run_instr(legal_ops[$urandom_range(5)], 65, $sformatf("rnd%0d", n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1, selects behaviour on an undefined opcode: 1 halts in ILLEGAL, 0 returns to FETCH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 opcode  input  6  instruction_register[31:26], valid from DECODE onward.
REQ-005 mem_ready  input  1  memory completes the current MemRead/MemWrite this cycle.
REQ-006 zero  input  1  ALU zero flag, used in BRANCH.
REQ-007 IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, PCWriteCond  output  1 each  standard multicycle datapath controls.
REQ-008 ALUSrcB, ALUOp, PCSource  output  2 each  mux selects and ALU op class.
REQ-009 pc_en  output  1  PC load enable = PCWrite | (PCWriteCond & zero).
REQ-010 illegal_op  output  1  high while in ILLEGAL.
REQ-011 state_dbg  output  4  current state encoding.

Function
REQ-012 States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, ILLEGAL.
REQ-013 Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000; all others are illegal.
REQ-014 Transitions: FETCH->DECODE only when mem_ready=1, else stay in FETCH.
REQ-015 DECODE branches on opcode: lw/sw->MEM_ADR, R->EXECUTE, beq->BRANCH, j->JUMP, addi->ADDI_EX, other->ILLEGAL.
REQ-016 MEM_ADR branches on opcode: lw->MEM_READ, sw->MEM_WRITE.
REQ-017 MEM_READ->MEM_WB and MEM_WRITE->FETCH occur only on mem_ready=1, else the FSM holds.
REQ-018 Fixed transitions: MEM_WB->FETCH, EXECUTE->R_WB->FETCH, BRANCH->FETCH, JUMP->FETCH, ADDI_EX->ADDI_WB->FETCH.
REQ-019 ILLEGAL holds when HALT_ON_ILLEGAL=1 and goes to FETCH next cycle when HALT_ON_ILLEGAL=0.
REQ-020 Any output not listed for a state is 0.
REQ-021 FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready (Mealy).
REQ-022 DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-023 MEM_ADR and ADDI_EX outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-024 MEM_READ outputs: MemRead=1, IorD=1.
REQ-025 MEM_WRITE outputs: MemWrite=1, IorD=1.
REQ-026 MEM_WB outputs: RegDst=0, MemtoReg=1, RegWrite=1.
REQ-027 EXECUTE outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-028 R_WB outputs: RegDst=1, MemtoReg=0, RegWrite=1.
REQ-029 ADDI_WB outputs: RegDst=0, MemtoReg=0, RegWrite=1.
REQ-030 BRANCH outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-031 JUMP outputs: PCWrite=1, PCSource=10.
REQ-032 Latency with mem_ready tied high, in cycles FETCH-to-FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3; each mem_ready=0 cycle in a memory state adds 1.
REQ-033 MemRead and MemWrite shall never be high in the same cycle.
REQ-034 IRWrite shall be high only in FETCH.
REQ-035 pc_en is combinational in the same cycle as its sources.

Reset
REQ-036 reset=0 forces the state to FETCH asynchronously, including mid-instruction and while a memory access is pending.
REQ-037 While reset=0, all control outputs, pc_en and illegal_op shall be 0, and state_dbg shall show the FETCH encoding.
REQ-038 The first FETCH access begins on the first rising edge after reset deasserts.

Structure
REQ-039 Package mc_pkg holds the state enum, the opcode constants, and the ALUOp, ALUSrcB and PCSource encodings.
REQ-040 One sub-module, mc_control_decode, maps state, mem_ready and zero to the control outputs combinationally; mc_control keeps only the state register and next-state logic.

Verification
REQ-041 lw with mem_ready=1 -> state sequence FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, FETCH; RegWrite=1 and MemtoReg=1 in cycle 5 only.
REQ-042 sw with mem_ready held 0 for 3 cycles in MEM_WRITE -> MemWrite=1 for 4 cycles; FETCH re-entered after the mem_ready=1 cycle; RegWrite never asserted.
REQ-043 beq with zero=1 -> pc_en=1 and PCSource=01 in the BRANCH cycle; beq with zero=0 -> pc_en=0 throughout BRANCH.
REQ-044 FETCH with mem_ready=0 for 2 cycles -> IRWrite=PCWrite=0 for those cycles, then both =1 for one cycle; DECODE follows.
REQ-045 opcode 111111 -> ILLEGAL with illegal_op=1 held for 10+ cycles (HALT_ON_ILLEGAL=1); with HALT_ON_ILLEGAL=0 -> FETCH on the next cycle.
REQ-046 reset=0 asserted mid-MEM_READ -> all outputs 0 immediately; after release, MemRead=1 with IorD=0 on the first cycle.
